// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU issue controller and its register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN   = 16;
    localparam int ILEN   = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [3:0] OP_0   = 4'd0;
    localparam logic [3:0] OP_1   = 4'd1;
    localparam logic [3:0] OP_2   = 4'd2;
    localparam logic [3:0] OP_3   = 4'd3;
    localparam logic [3:0] OP_4   = 4'd4;
    localparam logic [3:0] OP_5   = 4'd5;
    localparam logic [3:0] MAX_OP = OP_5;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int CIN_BIT = 2;
    localparam int BIN_BIT = 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    // Field order matches the instruction word so a plain cast decodes it.
    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              cin;
        logic              bin;
        logic              rsvd;
    } instr_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus the combinational ALU drive/return bundle.
// Latency: n/a (wires only).
// Backpressure: instr_ready from the master side throttles instr_valid.
interface alu_issue_ctrl_if;

    logic                      instr_valid;
    logic [cpu_pkg::ILEN-1:0]  instr;
    logic                      instr_ready;
    logic [3:0]                op_code;
    logic [cpu_pkg::XLEN-1:0]  rs1_in;
    logic [cpu_pkg::XLEN-1:0]  rs2_in;
    logic                      cin;
    logic                      bin;
    logic [cpu_pkg::XLEN-1:0]  alu_result;

    modport master (
        input  instr_valid, instr, alu_result,
        output instr_ready, op_code, rs1_in, rs2_in, cin, bin
    );

    modport slave (
        output instr_valid, instr, alu_result,
        input  instr_ready, op_code, rs1_in, rs2_in, cin, bin
    );

endinterface

// File: rtl/cpu_regfile.sv
// 8x16 register file: two operand reads, one debug read, writeback and host write ports.
// Latency: reads combinational, writes land at the clock edge.
// Backpressure: none; a host write colliding with writeback is dropped and flagged.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              host_en,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [XLEN-1:0]   host_data,
    output logic              host_drop
);

    logic [XLEN-1:0] regs [NREGS];

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];
    assign host_drop = host_en && wb_en && (host_addr == wb_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_en && !host_drop) begin
                regs[host_addr] <= host_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the combinational ALU and writes the result back.
// Latency: accept edge -> ALU driven next cycle -> done the cycle after; 1 instr / 3 cycles.
// Backpressure: instr_ready is high only in IDLE; unaccepted instr_valid is ignored.
module alu_issue_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.master  alu_if,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic              wr_drop,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic              done,
    output logic [XLEN-1:0]   done_result,
    output logic              illegal
);

    state_t          state_q, state_d;
    instr_t          ir_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] rs1_data, rs2_data, dbg_raw;
    logic            legal, wb_en, drop_raw;

    assign legal = (ir_q.op <= MAX_OP);

    cpu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (ir_q.rs1),
        .rd_addr_b (ir_q.rs2),
        .rd_data_a (rs1_data),
        .rd_data_b (rs2_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_raw),
        .wb_en     (wb_en),
        .wb_addr   (ir_q.rd),
        .wb_data   (result_q),
        .host_en   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .host_drop (drop_raw)
    );

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign dbg_data = rst ? '0 : dbg_raw;
    assign wr_drop  = !rst && drop_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && alu_if.instr_valid) begin
                ir_q <= instr_t'(alu_if.instr);
            end
            if (state_q == EXEC) begin
                result_q <= legal ? alu_if.alu_result : '0;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        alu_if.instr_ready = 1'b0;
        alu_if.op_code     = '0;
        alu_if.rs1_in      = '0;
        alu_if.rs2_in      = '0;
        alu_if.cin         = 1'b0;
        alu_if.bin         = 1'b0;
        done               = 1'b0;
        done_result        = '0;
        illegal            = 1'b0;
        wb_en              = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    alu_if.instr_ready = 1'b1;
                    if (alu_if.instr_valid) begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (legal) begin
                        alu_if.op_code = ir_q.op;
                        alu_if.rs1_in  = rs1_data;
                        alu_if.rs2_in  = rs2_data;
                        alu_if.cin     = ir_q.cin;
                        alu_if.bin     = ir_q.bin;
                    end
                    state_d = WB;
                end
                WB: begin
                    done        = 1'b1;
                    done_result = result_q;
                    illegal     = !legal;
                    wb_en       = legal;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
